// File: rtl/core_imem_if.sv
// core_imem_if: write-beat, pixel-read and status signals of the ping-pong
// input tile buffer. The optional pad strobe exists only when CORE_IMEM_PAD_EN
// is defined.
interface core_imem_if;
    logic        I_IM_WR_EN;
    logic [31:0] I_IM_WDATA;
    logic [7:0]  I_IM_WADDR0;
    logic [7:0]  I_IM_WADDR1;
    logic [7:0]  I_IM_WADDR2;
    logic [7:0]  I_IM_WADDR3;
    logic        O_IM_WR_READY;
    logic        I_IM_RD_EN;
    logic [7:0]  I_IM_RADDRB;
    logic [7:0]  I_IM_RADDRG;
    logic [7:0]  I_IM_RADDRR;
    logic [23:0] O_IM_RDATA;
    logic        O_IM_RDATA_VALID;
    logic        O_IM_RD_AVAIL;
    logic        I_IM_RD_DONE;
    logic        O_IM_OVERFLOW;
`ifdef CORE_IMEM_PAD_EN
    logic        I_IM_PAD;
`endif

    // The buffer itself
    modport slave (
        input  I_IM_WR_EN, I_IM_WDATA,
        input  I_IM_WADDR0, I_IM_WADDR1, I_IM_WADDR2, I_IM_WADDR3,
        output O_IM_WR_READY,
        input  I_IM_RD_EN, I_IM_RADDRB, I_IM_RADDRG, I_IM_RADDRR,
        output O_IM_RDATA, O_IM_RDATA_VALID, O_IM_RD_AVAIL,
        input  I_IM_RD_DONE,
`ifdef CORE_IMEM_PAD_EN
        input  I_IM_PAD,
`endif
        output O_IM_OVERFLOW
    );

    // The DMA writer / pixel reader driving the buffer
    modport master (
        output I_IM_WR_EN, I_IM_WDATA,
        output I_IM_WADDR0, I_IM_WADDR1, I_IM_WADDR2, I_IM_WADDR3,
        input  O_IM_WR_READY,
        output I_IM_RD_EN, I_IM_RADDRB, I_IM_RADDRG, I_IM_RADDRR,
        input  O_IM_RDATA, O_IM_RDATA_VALID, O_IM_RD_AVAIL,
        output I_IM_RD_DONE,
`ifdef CORE_IMEM_PAD_EN
        output I_IM_PAD,
`endif
        input  O_IM_OVERFLOW
    );
endinterface

// File: rtl/core_imem.sv
// core_imem: double-banked (ping-pong) input tile buffer, one 8x8 RGB tile
// (192 bytes) per bank. One bank fills from 32-bit byte-steered beats while
// the other drains one B/G/R pixel per read request with one cycle latency.
// Optional feature macro: CORE_IMEM_PAD_EN adds I_IM_PAD, which writes zeros
// in place of the beat data while still counting the beat.
// P_DEPTH must stay <= 256 because byte addresses are 8 bits wide.
module core_imem #(
    parameter int unsigned P_DEPTH = 192,
    parameter int unsigned P_BEATS = 48
) (
    input logic         I_IM_HCLK,
    input logic         I_IM_RESET,
    core_imem_if.slave  imem
);

    logic [7:0]  mem [2][P_DEPTH];

    logic [1:0]  full;
    logic [1:0]  full_next;
    logic        wr_bank;
    logic        rd_bank;
    logic [5:0]  beat_count;
    logic        overflow;
    logic [23:0] rdata;
    logic        rdata_valid;

    logic        wr_ready;
    logic        beat_accept;
    logic        fill_done;
    logic        rd_fire;
    logic        rd_release;
    logic [31:0] wdata_eff;
    logic [7:0]  waddr [4];
    logic [3:0]  waddr_ok;
    logic [7:0]  rd_b;
    logic [7:0]  rd_g;
    logic [7:0]  rd_r;

    assign wr_ready    = !full[wr_bank];
    assign beat_accept = imem.I_IM_WR_EN && wr_ready;
    assign fill_done   = beat_accept && (beat_count == 6'(P_BEATS - 1));
    assign rd_fire     = imem.I_IM_RD_EN && full[rd_bank];
    assign rd_release  = imem.I_IM_RD_DONE && full[rd_bank];

    assign imem.O_IM_WR_READY    = wr_ready;
    assign imem.O_IM_RD_AVAIL    = full[rd_bank];
    assign imem.O_IM_OVERFLOW    = overflow;
    assign imem.O_IM_RDATA       = rdata;
    assign imem.O_IM_RDATA_VALID = rdata_valid;

`ifdef CORE_IMEM_PAD_EN
    assign wdata_eff = imem.I_IM_PAD ? 32'h0 : imem.I_IM_WDATA;
`else
    assign wdata_eff = imem.I_IM_WDATA;
`endif

    // Collect the four byte addresses and flag the ones inside the bank
    always_comb begin
        waddr[0] = imem.I_IM_WADDR0;
        waddr[1] = imem.I_IM_WADDR1;
        waddr[2] = imem.I_IM_WADDR2;
        waddr[3] = imem.I_IM_WADDR3;
        waddr_ok = '0;
        for (int k = 0; k < 4; k++) begin
            waddr_ok[k] = (32'(waddr[k]) < P_DEPTH);
        end
    end

    // Byte-steered bank write; later byte lanes override earlier ones on an address clash
    always_ff @(posedge I_IM_HCLK) begin
        if (beat_accept) begin
            for (int k = 0; k < 4; k++) begin
                if (waddr_ok[k]) begin
                    mem[wr_bank][waddr[k]] <= wdata_eff[8*k +: 8];
                end
            end
        end
    end

    // Fetch the three components of the requested pixel, zero when out of range
    always_comb begin
        rd_b = '0;
        rd_g = '0;
        rd_r = '0;
        if (32'(imem.I_IM_RADDRB) < P_DEPTH) rd_b = mem[rd_bank][imem.I_IM_RADDRB];
        if (32'(imem.I_IM_RADDRG) < P_DEPTH) rd_g = mem[rd_bank][imem.I_IM_RADDRG];
        if (32'(imem.I_IM_RADDRR) < P_DEPTH) rd_r = mem[rd_bank][imem.I_IM_RADDRR];
    end

    // Next full flags: completing fill sets one bank, release clears the other
    always_comb begin
        full_next = full;
        if (fill_done)  full_next[wr_bank] = 1'b1;
        if (rd_release) full_next[rd_bank] = 1'b0;
    end

    // Bank bookkeeping: flags, fill/drain pointers, beat counter, sticky overflow
    always_ff @(posedge I_IM_HCLK) begin
        if (I_IM_RESET) begin
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            beat_count <= '0;
            overflow   <= 1'b0;
        end else begin
            full <= full_next;
            if (beat_accept) begin
                if (fill_done) begin
                    beat_count <= '0;
                    wr_bank    <= ~wr_bank;
                end else begin
                    beat_count <= beat_count + 6'd1;
                end
            end
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end
            if (imem.I_IM_WR_EN && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Registered pixel output; data holds when no read is serviced
    always_ff @(posedge I_IM_HCLK) begin
        if (I_IM_RESET) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= rd_fire;
            if (rd_fire) begin
                rdata <= {rd_r, rd_g, rd_b};
            end
        end
    end

endmodule

// File: tb/tb_core_imem.sv
// tb_core_imem: directed test of the ping-pong input tile buffer core_imem.
// Pad checks are included only when CORE_IMEM_PAD_EN is defined.
module tb_core_imem;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    core_imem_if bus ();

    core_imem dut (
        .I_IM_HCLK  (clk),
        .I_IM_RESET (rst),
        .imem       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int n);
        return 32'(n) * 32'h04040404 + 32'h03020100;
    endfunction

    // One write beat at the current negedge, released at the next negedge
    task automatic drive_beat(input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3,
                              input logic [31:0] d);
        bus.I_IM_WR_EN  = 1'b1;
        bus.I_IM_WADDR0 = a0;
        bus.I_IM_WADDR1 = a1;
        bus.I_IM_WADDR2 = a2;
        bus.I_IM_WADDR3 = a3;
        bus.I_IM_WDATA  = d;
        @(negedge clk);
        bus.I_IM_WR_EN  = 1'b0;
    endtask

    task automatic write_pattern_beat(input int n, input logic [31:0] mask);
        drive_beat(8'(4*n), 8'(4*n+1), 8'(4*n+2), 8'(4*n+3), pattern(n) ^ mask);
    endtask

    task automatic issue_read(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        bus.I_IM_RD_EN  = 1'b1;
        bus.I_IM_RADDRB = b;
        bus.I_IM_RADDRG = g;
        bus.I_IM_RADDRR = r;
        @(negedge clk);
        bus.I_IM_RD_EN  = 1'b0;
    endtask

    task automatic pulse_done();
        bus.I_IM_RD_DONE = 1'b1;
        @(negedge clk);
        bus.I_IM_RD_DONE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.O_IM_WR_READY !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_wr_ready: got %b, expected 1", bus.O_IM_WR_READY);
        end
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd_avail: got %b, expected 0", bus.O_IM_RD_AVAIL);
        end
        compared++;
        if (bus.O_IM_RDATA !== 24'h0 || bus.O_IM_RDATA_VALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_rdata: got %h/%b, expected 000000/0", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
        compared++;
        if (bus.O_IM_OVERFLOW !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_overflow: got %b, expected 0", bus.O_IM_OVERFLOW);
        end
        rst = 1'b0;
        // Read while nothing is full must be ignored
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA_VALID !== 1'b0 || bus.O_IM_RDATA !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL empty_read: got %h/%b, expected 000000/0", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
    endtask

    task automatic test_fill();
        for (int n = 0; n < 47; n++) write_pattern_beat(n, 32'h0);
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL avail_before_last: got %b, expected 0", bus.O_IM_RD_AVAIL);
        end
        write_pattern_beat(47, 32'h0);
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b1 || bus.O_IM_WR_READY !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fill_done: got avail=%b ready=%b, expected 1/1", bus.O_IM_RD_AVAIL, bus.O_IM_WR_READY);
        end
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA !== 24'h020100 || bus.O_IM_RDATA_VALID !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL read_first: got %h/%b, expected 020100/1", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
    endtask

    task automatic test_back_to_back();
        issue_read(8'd10, 8'd11, 8'd12);
        compared++;
        if (bus.O_IM_RDATA !== 24'h0C0B0A || bus.O_IM_RDATA_VALID !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_read0: got %h/%b, expected 0c0b0a/1", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
        issue_read(8'd191, 8'd190, 8'd189);
        compared++;
        if (bus.O_IM_RDATA !== 24'hBDBEBF || bus.O_IM_RDATA_VALID !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_read1: got %h/%b, expected bdbebf/1", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
        @(negedge clk);
        compared++;
        if (bus.O_IM_RDATA_VALID !== 1'b0 || bus.O_IM_RDATA !== 24'hBDBEBF) begin
            mismatched++;
            $display("[TB] FAIL read_idle_hold: got %h/%b, expected bdbebf/0", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 48; n++) write_pattern_beat(n, 32'h80808080);
        compared++;
        if (bus.O_IM_WR_READY !== 1'b0 || bus.O_IM_OVERFLOW !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL both_full: got ready=%b ovf=%b, expected 0/0", bus.O_IM_WR_READY, bus.O_IM_OVERFLOW);
        end
        drive_beat(8'd0, 8'd1, 8'd2, 8'd3, 32'hDEADBEEF);
        compared++;
        if (bus.O_IM_OVERFLOW !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overflow_set: got %b, expected 1", bus.O_IM_OVERFLOW);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (bus.O_IM_OVERFLOW !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overflow_sticky: got %b, expected 1", bus.O_IM_OVERFLOW);
        end
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA !== 24'h020100) begin
            mismatched++;
            $display("[TB] FAIL bank0_intact: got %h, expected 020100", bus.O_IM_RDATA);
        end
        pulse_done();
        compared++;
        if (bus.O_IM_WR_READY !== 1'b1 || bus.O_IM_RD_AVAIL !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL release0: got ready=%b avail=%b, expected 1/1", bus.O_IM_WR_READY, bus.O_IM_RD_AVAIL);
        end
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA !== 24'h828180) begin
            mismatched++;
            $display("[TB] FAIL bank1_read: got %h, expected 828180", bus.O_IM_RDATA);
        end
        compared++;
        if (bus.O_IM_OVERFLOW !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overflow_after_done: got %b, expected 1", bus.O_IM_OVERFLOW);
        end
    endtask

    task automatic test_range_and_simultaneous();
        // Bank 0 refills: byte 3 out of range, then a four-way address clash
        drive_beat(8'd0, 8'd1, 8'd2, 8'hC0, 32'hAABBCCDD);
        drive_beat(8'd5, 8'd5, 8'd5, 8'd5, 32'h44332211);
        for (int n = 2; n < 47; n++) write_pattern_beat(n, 32'h0);
        compared++;
        if (bus.O_IM_WR_READY !== 1'b1 || bus.O_IM_RD_AVAIL !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pre_simul: got ready=%b avail=%b, expected 1/1", bus.O_IM_WR_READY, bus.O_IM_RD_AVAIL);
        end
        bus.I_IM_RD_DONE = 1'b1;
        write_pattern_beat(47, 32'h0);
        bus.I_IM_RD_DONE = 1'b0;
        compared++;
        if (bus.O_IM_WR_READY !== 1'b1 || bus.O_IM_RD_AVAIL !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL simul: got ready=%b avail=%b, expected 1/1", bus.O_IM_WR_READY, bus.O_IM_RD_AVAIL);
        end
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA !== 24'hBBCCDD) begin
            mismatched++;
            $display("[TB] FAIL range_bytes: got %h, expected bbccdd", bus.O_IM_RDATA);
        end
        issue_read(8'd0, 8'd1, 8'hC0);
        compared++;
        if (bus.O_IM_RDATA !== 24'h00CCDD) begin
            mismatched++;
            $display("[TB] FAIL range_read_zero: got %h, expected 00ccdd", bus.O_IM_RDATA);
        end
        issue_read(8'd5, 8'd4, 8'd6);
        compared++;
        if (bus.O_IM_RDATA !== 24'h060444) begin
            mismatched++;
            $display("[TB] FAIL collision: got %h, expected 060444", bus.O_IM_RDATA);
        end
        // Read issued together with the release still sees the released bank
        bus.I_IM_RD_DONE = 1'b1;
        issue_read(8'd100, 8'd150, 8'd191);
        bus.I_IM_RD_DONE = 1'b0;
        compared++;
        if (bus.O_IM_RDATA !== 24'hBF9664 || bus.O_IM_RDATA_VALID !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL read_with_done: got %h/%b, expected bf9664/1", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b0 || bus.O_IM_WR_READY !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL all_empty: got avail=%b ready=%b, expected 0/1", bus.O_IM_RD_AVAIL, bus.O_IM_WR_READY);
        end
        pulse_done();
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA_VALID !== 1'b0 || bus.O_IM_RDATA !== 24'hBF9664) begin
            mismatched++;
            $display("[TB] FAIL ignored_read: got %h/%b, expected bf9664/0", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int n = 0; n < 20; n++) write_pattern_beat(n, 32'h22222222);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if (bus.O_IM_WR_READY !== 1'b1 || bus.O_IM_RD_AVAIL !== 1'b0 || bus.O_IM_OVERFLOW !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got ready=%b avail=%b ovf=%b, expected 1/0/0", bus.O_IM_WR_READY, bus.O_IM_RD_AVAIL, bus.O_IM_OVERFLOW);
        end
        compared++;
        if (bus.O_IM_RDATA !== 24'h0 || bus.O_IM_RDATA_VALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_rdata: got %h/%b, expected 000000/0", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
        for (int n = 0; n < 47; n++) write_pattern_beat(n, 32'h55555555);
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL refill_early: got %b, expected 0", bus.O_IM_RD_AVAIL);
        end
        write_pattern_beat(47, 32'h55555555);
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b1 || bus.O_IM_WR_READY !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL refill_done: got avail=%b ready=%b, expected 1/1", bus.O_IM_RD_AVAIL, bus.O_IM_WR_READY);
        end
        issue_read(8'd0, 8'd1, 8'd2);
        compared++;
        if (bus.O_IM_RDATA !== 24'h575455) begin
            mismatched++;
            $display("[TB] FAIL refill_read: got %h, expected 575455", bus.O_IM_RDATA);
        end
    endtask

`ifdef CORE_IMEM_PAD_EN
    task automatic test_pad();
        write_pattern_beat(0, 32'h0);
        bus.I_IM_PAD = 1'b1;
        drive_beat(8'd4, 8'd5, 8'd6, 8'd7, 32'hFFFFFFFF);
        bus.I_IM_PAD = 1'b0;
        for (int n = 2; n < 48; n++) write_pattern_beat(n, 32'h0);
        pulse_done();
        compared++;
        if (bus.O_IM_RD_AVAIL !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pad_avail: got %b, expected 1", bus.O_IM_RD_AVAIL);
        end
        issue_read(8'd4, 8'd5, 8'd6);
        compared++;
        if (bus.O_IM_RDATA !== 24'h000000 || bus.O_IM_RDATA_VALID !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL pad_zero: got %h/%b, expected 000000/1", bus.O_IM_RDATA, bus.O_IM_RDATA_VALID);
        end
        issue_read(8'd8, 8'd9, 8'd10);
        compared++;
        if (bus.O_IM_RDATA !== 24'h0A0908) begin
            mismatched++;
            $display("[TB] FAIL pad_neighbour: got %h, expected 0a0908", bus.O_IM_RDATA);
        end
    endtask
`endif

    initial begin
        compared         = 0;
        mismatched       = 0;
        rst              = 1'b1;
        bus.I_IM_WR_EN   = 1'b0;
        bus.I_IM_WDATA   = '0;
        bus.I_IM_WADDR0  = '0;
        bus.I_IM_WADDR1  = '0;
        bus.I_IM_WADDR2  = '0;
        bus.I_IM_WADDR3  = '0;
        bus.I_IM_RD_EN   = 1'b0;
        bus.I_IM_RADDRB  = '0;
        bus.I_IM_RADDRG  = '0;
        bus.I_IM_RADDRR  = '0;
        bus.I_IM_RD_DONE = 1'b0;
`ifdef CORE_IMEM_PAD_EN
        bus.I_IM_PAD     = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_fill();
        test_back_to_back();
        test_overflow();
        test_range_and_simultaneous();
        test_reset_mid_fill();
`ifdef CORE_IMEM_PAD_EN
        test_pad();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
